// File: rtl/cs_bist_ctrl.sv
// -----------------------------------------------------------------------------
// cs_bist_ctrl
//   Built-in self-test controller for the CS block. It streams a stored X
//   sample sequence from an input ROM into CS, compares each CS Y output
//   against a golden ROM, and reports pass/fail, the mismatch count and the
//   index of the first mismatch.
//
// Ports
//   clk, reset        system clock (posedge), synchronous active-high reset
//   start             level; launches a run when sampled in IDLE or DONE
//   in_addr/in_data   input ROM port (data valid one cycle after address)
//   gold_addr/gold_data golden ROM port (data valid one cycle after address)
//   cs_reset, cs_x    reset and registered X sample driven to CS
//   cs_y              Y output returned by CS
//   busy, done, pass  status (busy in RST/STREAM, done in DONE)
//   err_cnt           saturating mismatch count
//   first_err_idx     golden index of the first mismatch, all-ones = none
//
// Optional build macro BIST_LOG_EN adds a registered mismatch log:
//   err_valid, err_idx, err_got, err_exp
//
// Schedule: stream cycle s=0 holds sample 0 on cs_x. Golden entry k is
// compared at the edge ending stream cycle k+WIN-1+CS_LAT, so the last
// compare ends cycle N_PAT-1+CS_LAT and the run lasts 1+RST_CYC+N_PAT+CS_LAT
// cycles from the start-sampling cycle to the first DONE cycle.
// -----------------------------------------------------------------------------
module cs_bist_ctrl #(
    parameter int N_PAT   = 2000,
    parameter int AW      = 15,
    parameter int WIN     = 9,
    parameter int RST_CYC = 2,
    parameter int CS_LAT  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] in_addr,
    input  logic [7:0]    in_data,
    output logic [AW-1:0] gold_addr,
    input  logic [9:0]    gold_data,
    output logic          cs_reset,
    output logic [7:0]    cs_x,
    input  logic [9:0]    cs_y,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] err_cnt,
    output logic [AW-1:0] first_err_idx
`ifdef BIST_LOG_EN
    ,
    output logic          err_valid,
    output logic [AW-1:0] err_idx,
    output logic [9:0]    err_got,
    output logic [9:0]    err_exp
`endif
);

    localparam int RCW = $clog2(RST_CYC + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RST    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [RCW-1:0] R_LAST  = RCW'(RST_CYC - 1);
    localparam logic [AW:0]    S_LAST  = (AW+1)'(N_PAT - 1 + CS_LAT);
    localparam logic [AW:0]    S_XLAST = (AW+1)'(N_PAT - 1);
    localparam logic [AW:0]    S_CMP0  = (AW+1)'(WIN - 1 + CS_LAT);
    localparam logic [AW:0]    S_GOLD0 = (AW+1)'(WIN - 2 + CS_LAT);
    localparam logic [AW:0]    A_LAST  = (AW+1)'(N_PAT - 1);
    localparam logic [AW:0]    K_LAST  = (AW+1)'(N_PAT - WIN);

    logic [1:0]     state;
    logic [RCW-1:0] rst_cnt;
    logic [AW:0]    s_cnt;

    logic [AW:0]    s_plus2;
    logic [AW:0]    s_gold;
    logic [AW:0]    cmp_k;
    logic           cmp_en;
    logic           mismatch;

    assign cs_reset = (state == ST_RST);
    assign busy     = (state == ST_RST) || (state == ST_STREAM);
    assign done     = (state == ST_DONE);
    assign pass     = done && (err_cnt == '0);

    // ROM addresses are decoded from the cycle counters; both clamp at their
    // last entry so DONE simply holds the final values.
    always_comb begin
        in_addr   = '0;
        gold_addr = '0;
        s_plus2   = s_cnt + (AW+1)'(2);
        s_gold    = s_cnt - S_GOLD0;
        cmp_k     = s_cnt - S_CMP0;
        cmp_en    = (state == ST_STREAM) && (s_cnt >= S_CMP0);
        mismatch  = cmp_en && (cs_y != gold_data);
        case (state)
            ST_RST: begin
                in_addr = (rst_cnt == R_LAST) ? AW'(1) : '0;
            end
            ST_STREAM: begin
                in_addr = (s_plus2 >= A_LAST) ? A_LAST[AW-1:0] : s_plus2[AW-1:0];
                if (s_cnt <= S_GOLD0)
                    gold_addr = '0;
                else if (s_gold >= K_LAST)
                    gold_addr = K_LAST[AW-1:0];
                else
                    gold_addr = s_gold[AW-1:0];
            end
            ST_DONE: begin
                in_addr   = A_LAST[AW-1:0];
                gold_addr = K_LAST[AW-1:0];
            end
            default: begin
                in_addr   = '0;
                gold_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rst_cnt       <= '0;
            s_cnt         <= '0;
            cs_x          <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
`ifdef BIST_LOG_EN
            err_valid     <= 1'b0;
            err_idx       <= '0;
            err_got       <= '0;
            err_exp       <= '0;
`endif
        end else begin
`ifdef BIST_LOG_EN
            err_valid <= 1'b0;
            err_idx   <= '0;
            err_got   <= '0;
            err_exp   <= '0;
`endif
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_RST;
                        rst_cnt       <= '0;
                        cs_x          <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '1;
                    end
                end
                ST_RST: begin
                    if (rst_cnt == R_LAST) begin
                        // Sample 0 was addressed in the previous cycle.
                        state <= ST_STREAM;
                        s_cnt <= '0;
                        cs_x  <= in_data;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (s_cnt < S_XLAST)
                        cs_x <= in_data;
                    if (mismatch) begin
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0)
                            first_err_idx <= cmp_k[AW-1:0];
`ifdef BIST_LOG_EN
                        err_valid <= 1'b1;
                        err_idx   <= cmp_k[AW-1:0];
                        err_got   <= cs_y;
                        err_exp   <= gold_data;
`endif
                    end
                    if (s_cnt == S_LAST)
                        state <= ST_DONE;
                    else
                        s_cnt <= s_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_bist_ctrl.sv
module tb_cs_bist_ctrl;

    localparam int N_PAT = 2000;
    localparam int AW    = 15;
    localparam int WIN   = 9;
    localparam int NG    = N_PAT - WIN + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] in_addr;
    logic [7:0]    in_data;
    logic [AW-1:0] gold_addr;
    logic [9:0]    gold_data;
    logic          cs_reset;
    logic [7:0]    cs_x;
    logic [9:0]    cs_y;
    logic          busy, done, pass;
    logic [AW-1:0] err_cnt, first_err_idx;
`ifdef BIST_LOG_EN
    logic          err_valid;
    logic [AW-1:0] err_idx;
    logic [9:0]    err_got, err_exp;
    int            log_idx_q[$];
    int            log_got_q[$];
    int            log_exp_q[$];
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] in_rom [N_PAT];
    logic [9:0] gold_rom [NG];
    logic       stub = 1'b0;
    logic [7:0] hist [WIN-1];

    int obs_addr_r0, obs_addr_r1, obs_x0;

    always #5 clk = ~clk;

    cs_bist_ctrl #(.N_PAT(N_PAT), .AW(AW), .WIN(WIN), .RST_CYC(2), .CS_LAT(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_addr(in_addr), .in_data(in_data),
        .gold_addr(gold_addr), .gold_data(gold_data),
        .cs_reset(cs_reset), .cs_x(cs_x), .cs_y(cs_y),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx)
`ifdef BIST_LOG_EN
        , .err_valid(err_valid), .err_idx(err_idx), .err_got(err_got), .err_exp(err_exp)
`endif
    );

    // Synchronous ROMs
    always @(posedge clk) begin
        in_data   <= (int'(in_addr) < N_PAT) ? in_rom[in_addr] : 8'h00;
        gold_data <= (int'(gold_addr) < NG) ? gold_rom[gold_addr] : 10'h000;
    end

    // CS model: Y is the 10-bit sum of the current X and the previous WIN-1 X's.
    always @(posedge clk) begin
        for (int i = 0; i < WIN - 1; i++)
            hist[i] <= cs_reset ? 8'h00 : (i == 0 ? cs_x : hist[i-1]);
    end
    always_comb begin
        logic [11:0] acc;
        acc = 12'(cs_x);
        for (int i = 0; i < WIN - 1; i++) acc = acc + 12'(hist[i]);
        cs_y = stub ? 10'h000 : acc[9:0];
    end

`ifdef BIST_LOG_EN
    always @(negedge clk) begin
        if (err_valid) begin
            log_idx_q.push_back(int'(err_idx));
            log_got_q.push_back(int'(err_got));
            log_exp_q.push_back(int'(err_exp));
        end
    end
`endif

    // Reference: Y expected for golden entry k, directly from the sample list.
    function automatic logic [9:0] ref_y(int k);
        int sum = 0;
        if (stub) return 10'h000;
        for (int j = 0; j < WIN; j++) sum += int'(in_rom[k+j]);
        return 10'(sum);
    endfunction

    task automatic fill_inputs();
        for (int i = 0; i < N_PAT; i++) in_rom[i] = 8'($urandom);
    endtask

    task automatic fill_gold();
        for (int k = 0; k < NG; k++) gold_rom[k] = ref_y(k);
    endtask

    task automatic expect_errors(output int cnt, output int first);
        cnt = 0;
        first = 32'h7FFF;
        for (int k = 0; k < NG; k++)
            if (gold_rom[k] != ref_y(k)) begin
                if (cnt == 0) first = k;
                cnt++;
            end
    endtask

    // Launch from IDLE/DONE and count cycles until done is first seen.
    task automatic run_bist(output int lat, output int rst_cycles);
        lat = 0;
        rst_cycles = 0;
        #1 start = 1'b1;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (cs_reset) rst_cycles++;
            if (n == 1) obs_addr_r0 = int'(in_addr);
            if (n == 2) obs_addr_r1 = int'(in_addr);
            if (n == 3) obs_x0 = int'(cs_x);
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL run_timeout: done not seen within 5000 cycles");
        end
    endtask

    task automatic check_result(string name, int exp_cnt, int exp_first);
        checks++;
        if (err_cnt !== AW'(exp_cnt)) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_cnt);
        end
        checks++;
        if (first_err_idx !== AW'(exp_first)) begin
            errors++;
            $display("FAIL %s first_err_idx: got %0d expected %0d", name, first_err_idx, exp_first);
        end
        checks++;
        if (pass !== (exp_cnt == 0)) begin
            errors++;
            $display("FAIL %s pass: got %0b expected %0b", name, pass, exp_cnt == 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, cs_reset} !== 4'b0000 || cs_x !== 8'h00 ||
            err_cnt !== '0 || first_err_idx !== 15'h7FFF || in_addr !== '0 || gold_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b pass=%0b cs_reset=%0b cs_x=%0h err_cnt=%0d first=%0h in_addr=%0d gold_addr=%0d expected all zero, first=7fff",
                     busy, done, pass, cs_reset, cs_x, err_cnt, first_err_idx, in_addr, gold_addr);
        end
`ifdef BIST_LOG_EN
        checks++;
        if ({err_valid, err_idx, err_got, err_exp} !== '0) begin
            errors++;
            $display("FAIL reset_log: got %0b/%0d/%0h/%0h expected zeros", err_valid, err_idx, err_got, err_exp);
        end
`endif
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy got %0b expected 0", busy);
        end
    endtask

    task automatic test_clean();
        int lat, rc;
        fill_gold();
        run_bist(lat, rc);
        checks++;
        if (lat != 2003) begin
            errors++;
            $display("FAIL clean_latency: got %0d expected 2003", lat);
        end
        checks++;
        if (rc != 2 || obs_addr_r0 != 0 || obs_addr_r1 != 1) begin
            errors++;
            $display("FAIL clean_rst_phase: cs_reset cycles %0d addr %0d,%0d expected 2 cycles addr 0,1", rc, obs_addr_r0, obs_addr_r1);
        end
        checks++;
        if (obs_x0 != int'(in_rom[0])) begin
            errors++;
            $display("FAIL clean_first_x: got %0h expected %0h", obs_x0, in_rom[0]);
        end
        checks++;
        if (cs_x !== in_rom[N_PAT-1] || cs_reset !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: cs_x %0h cs_reset %0b expected %0h 0", cs_x, cs_reset, in_rom[N_PAT-1]);
        end
        check_result("clean", 0, 32'h7FFF);
    endtask

    task automatic test_single_flip();
        int lat, rc;
        fill_gold();
        gold_rom[5] = gold_rom[5] ^ 10'h001;
        run_bist(lat, rc);
        check_result("flip5", 1, 5);
    endtask

    task automatic test_stub();
        int lat, rc, ec, fe;
        stub = 1'b0;
        fill_gold();
        for (int k = 0; k < NG; k++) if (gold_rom[k] == 10'h000) gold_rom[k] = 10'h001;
        stub = 1'b1;
        expect_errors(ec, fe);
        run_bist(lat, rc);
        check_result("stub", ec, fe);
        checks++;
        if (err_cnt !== AW'(1992)) begin
            errors++;
            $display("FAIL stub_total: got %0d expected 1992", err_cnt);
        end
        stub = 1'b0;
    endtask

    task automatic test_mid_reset();
        int lat, rc;
        fill_gold();
        gold_rom[10] = ~gold_rom[10];
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (102) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || err_cnt !== AW'(1) || first_err_idx !== AW'(10)) begin
            errors++;
            $display("FAIL mid_before: busy %0b err_cnt %0d first %0d expected 1 1 10", busy, err_cnt, first_err_idx);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== '0 || first_err_idx !== 15'h7FFF || cs_reset !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy %0b done %0b err_cnt %0d first %0h cs_reset %0b expected 0 0 0 7fff 0",
                     busy, done, err_cnt, first_err_idx, cs_reset);
        end
        fill_gold();
        run_bist(lat, rc);
        checks++;
        if (lat != 2003) begin
            errors++;
            $display("FAIL mid_rerun_latency: got %0d expected 2003", lat);
        end
        check_result("mid_rerun", 0, 32'h7FFF);
    endtask

    task automatic test_start_handling();
        int lat;
        fill_gold();
        gold_rom[7] = gold_rom[7] + 10'd3;
        lat = 0;
        #1 start = 1'b1;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk);
            #1;
            start = (n == 50);
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 2003) begin
            errors++;
            $display("FAIL start_ignored_latency: got %0d expected 2003", lat);
        end
        check_result("start_busy", 1, 7);
        fill_gold();
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || cs_reset !== 1'b1 || err_cnt !== '0 || first_err_idx !== 15'h7FFF) begin
            errors++;
            $display("FAIL relaunch: done %0b busy %0b cs_reset %0b err_cnt %0d first %0h expected 0 1 1 0 7fff",
                     done, busy, cs_reset, err_cnt, first_err_idx);
        end
        start = 1'b0;
        for (int n = 0; n < 5000 && !done; n++) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL relaunch_result: done %0b pass %0b expected 1 1", done, pass);
        end
    endtask

    task automatic test_random();
        int lat, rc, ec, fe, nc, k;
        for (int it = 0; it < 3; it++) begin
            fill_inputs();
            fill_gold();
            nc = $urandom_range(0, 5);
            for (int j = 0; j < nc; j++) begin
                k = (j == 0) ? ((it == 1) ? NG - 1 : 0) : $urandom_range(0, NG - 1);
                gold_rom[k] = ref_y(k) ^ 10'($urandom_range(1, 1023));
            end
            expect_errors(ec, fe);
            run_bist(lat, rc);
            check_result($sformatf("random%0d", it), ec, fe);
        end
    endtask

`ifdef BIST_LOG_EN
    task automatic test_log();
        int lat, rc;
        fill_gold();
        gold_rom[3]    = gold_rom[3] ^ 10'h2A5;
        gold_rom[1991] = gold_rom[1991] ^ 10'h100;
        log_idx_q.delete();
        log_got_q.delete();
        log_exp_q.delete();
        run_bist(lat, rc);
        checks++;
        if (log_idx_q.size() != 2) begin
            errors++;
            $display("FAIL log_count: got %0d pulses expected 2", log_idx_q.size());
        end else begin
            checks++;
            if (log_idx_q[0] != 3 || log_idx_q[1] != 1991) begin
                errors++;
                $display("FAIL log_idx: got %0d,%0d expected 3,1991", log_idx_q[0], log_idx_q[1]);
            end
            checks++;
            if (log_exp_q[0] != int'(gold_rom[3]) || log_exp_q[1] != int'(gold_rom[1991]) ||
                log_got_q[0] != int'(ref_y(3)) || log_got_q[1] != int'(ref_y(1991))) begin
                errors++;
                $display("FAIL log_data: exp %0h,%0h got %0h,%0h expected exp %0h,%0h got %0h,%0h",
                         log_exp_q[0], log_exp_q[1], log_got_q[0], log_got_q[1],
                         gold_rom[3], gold_rom[1991], ref_y(3), ref_y(1991));
            end
        end
        check_result("log", 2, 3);
    endtask
`endif

    initial begin
        fill_inputs();
        fill_gold();
        test_reset();
        test_clean();
        test_single_flip();
        test_stub();
        test_mid_reset();
        test_start_handling();
        test_random();
`ifdef BIST_LOG_EN
        test_log();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
